// File: rtl/st2bus_turbo.sv
// st2bus_turbo: packs ST-bit decoder beats, lowest bits first, into BUS-bit words, NUM_BUS_PER_TURBO_PKT words per packet.
// Latency: 1 cycle from the beat that completes or ends a word to bus_valid.
// Backpressure: source_ready = !bus_valid || bus_ready. A stalled output word holds off the whole input.
// Ports: clk_st, rst (synchronous, active high); source_* beat input; bus_* word output; pkt_done pulse.
// Option: define ST2BUS_ERR_CNT_EN to add err_cnt[15:0], a saturating count of words emitted with bus_err=1.
// Assumes NUM_ST_PER_BUS > 1. A sop beat arriving mid-packet has its eop ignored.
module st2bus_turbo #(
    parameter int ST                    = 8,
    parameter int BUS                   = 512,
    parameter int NUM_ST_PER_BUS        = 64,
    parameter int NUM_BUS_PER_TURBO_PKT = 2
) (
    input  logic           clk_st,
    input  logic           rst,
    input  logic           source_valid,
    output logic           source_ready,
    input  logic           source_sop,
    input  logic           source_eop,
    input  logic [ST-1:0]  source_data_s,
    output logic [BUS-1:0] bus_data,
    output logic           bus_valid,
    input  logic           bus_ready,
    output logic           bus_last,
    output logic           bus_err,
    output logic           pkt_done
`ifdef ST2BUS_ERR_CNT_EN
    ,
    output logic [15:0]    err_cnt
`endif
);
    localparam int KW = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
    localparam int WW = (NUM_BUS_PER_TURBO_PKT > 1) ? $clog2(NUM_BUS_PER_TURBO_PKT) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NUM_ST_PER_BUS - 1);
    localparam logic [WW-1:0] W_LAST = WW'(NUM_BUS_PER_TURBO_PKT - 1);

    // DISCARD is the COLLECT-discard phase: it skips beats after a packet overran its size without eop.
    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;
    state_t state_q, state_d;

    logic [BUS-1:0] fill_q, fill_d;
    logic [KW-1:0]  k_q, k_d;
    logic [WW-1:0]  wcnt_q, wcnt_d;
    logic           drop_q, drop_d;

    logic           beat_fire;
    logic           take;       // beat is written into the packet at (wcnt_q, k_q)
    logic           flush;      // sop inside a packet closes the current partial word
    logic           word_end;
    logic           pkt_end;
    logic [BUS-1:0] merged;
    logic           emit;
    logic [BUS-1:0] emit_data;
    logic           emit_last;
    logic           emit_err;

    assign source_ready = !bus_valid || bus_ready;
    assign beat_fire    = source_valid && source_ready;
    assign word_end     = (k_q == K_LAST);
    assign pkt_end      = word_end && (wcnt_q == W_LAST);

    // k_q and wcnt_q are zero outside COLLECT, so a sop beat in IDLE or DISCARD lands at beat 0 of word 0.
    assign take  = beat_fire && (((state_q == IDLE || state_q == DISCARD) && source_sop) ||
                                 (state_q == COLLECT && !source_sop));
    assign flush = beat_fire && (state_q == COLLECT) && source_sop;

    always_comb begin
        merged = fill_q;
        merged[int'(k_q)*ST +: ST] = source_data_s;
    end

    // State register
    always_ff @(posedge clk_st) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (take) begin
            if (source_eop) begin
                state_d = IDLE;
            end else if (pkt_end) begin
                state_d = DISCARD;
            end else begin
                state_d = COLLECT;
            end
        end else if (flush) begin
            state_d = COLLECT;
        end else if (beat_fire && state_q == DISCARD && source_eop) begin
            state_d = IDLE;
        end
    end

    // Output and datapath decisions
    always_comb begin
        emit      = 1'b0;
        emit_data = merged;
        emit_last = 1'b0;
        emit_err  = 1'b0;
        fill_d    = fill_q;
        k_d       = k_q;
        wcnt_d    = wcnt_q;
        drop_d    = drop_q;
        if (flush) begin
            emit            = 1'b1;
            emit_data       = fill_q;
            emit_last       = 1'b1;
            emit_err        = 1'b1;
            fill_d          = '0;
            fill_d[ST-1:0]  = source_data_s;
            k_d             = KW'(1);
            wcnt_d          = '0;
        end else if (take) begin
            if (source_eop || word_end) begin
                emit      = 1'b1;
                emit_data = merged;
                emit_last = source_eop || pkt_end;
                // An eop that does not coincide with the final beat is an error either way round.
                emit_err  = drop_q || (source_eop != pkt_end);
                // The emitted word is cleared so a later early eop leaves the unfilled beats zero.
                fill_d    = '0;
                k_d       = '0;
                wcnt_d    = emit_last ? '0 : wcnt_q + 1'b1;
            end else begin
                fill_d = merged;
                k_d    = k_q + 1'b1;
            end
        end else if (beat_fire && state_q == IDLE) begin
            drop_d = 1'b1;
        end
        if (emit) begin
            drop_d = 1'b0;
        end
    end

    // Datapath and output registers. emit only happens when the output register is free or draining,
    // so the registered word stays stable while it is stalled.
    always_ff @(posedge clk_st) begin
        if (rst) begin
            fill_q    <= '0;
            k_q       <= '0;
            wcnt_q    <= '0;
            drop_q    <= 1'b0;
            bus_data  <= '0;
            bus_valid <= 1'b0;
            bus_last  <= 1'b0;
            bus_err   <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            fill_q   <= fill_d;
            k_q      <= k_d;
            wcnt_q   <= wcnt_d;
            drop_q   <= drop_d;
            pkt_done <= bus_valid && bus_ready && bus_last;
            if (emit) begin
                bus_valid <= 1'b1;
                bus_data  <= emit_data;
                bus_last  <= emit_last;
                bus_err   <= emit_err;
            end else if (bus_ready) begin
                bus_valid <= 1'b0;
            end
        end
    end

`ifdef ST2BUS_ERR_CNT_EN
    always_ff @(posedge clk_st) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (emit && emit_err && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_st2bus_turbo.sv
`timescale 1ns/1ps
module tb_st2bus_turbo;
    localparam int ST  = 8;
    localparam int BUS = 512;
    localparam int NST = 64;
    localparam int NBW = 2;
    localparam int PKT = NST * NBW;
    localparam int W   = BUS + 2;

    logic           clk_st = 1'b0;
    logic           rst = 1'b1;
    logic           source_valid = 1'b0;
    logic           source_sop = 1'b0;
    logic           source_eop = 1'b0;
    logic [ST-1:0]  source_data_s = '0;
    logic           bus_ready = 1'b1;
    logic           source_ready;
    logic [BUS-1:0] bus_data;
    logic           bus_valid;
    logic           bus_last;
    logic           bus_err;
    logic           pkt_done;
`ifdef ST2BUS_ERR_CNT_EN
    logic [15:0]    err_cnt;
`endif

    always #5 clk_st = ~clk_st;

    st2bus_turbo #(.ST(ST), .BUS(BUS), .NUM_ST_PER_BUS(NST), .NUM_BUS_PER_TURBO_PKT(NBW)) dut (
        .clk_st(clk_st), .rst(rst),
        .source_valid(source_valid), .source_ready(source_ready),
        .source_sop(source_sop), .source_eop(source_eop), .source_data_s(source_data_s),
        .bus_data(bus_data), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_last(bus_last), .bus_err(bus_err), .pkt_done(pkt_done)
`ifdef ST2BUS_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    logic [W-1:0] obs_q[$];     // {last, err, data} of each accepted word
    logic [W-1:0] exp_q[$];
    int pkt_cnt = 0;
    int exp_err_words = 0;
    int stall_seen = 0;

    // Reference model: whole-packet view of the beat stream.
    int          m_mode = 0;    // 0 between packets, 1 inside a packet, 2 skipping to eop
    byte unsigned m_pkt[$];
    bit          m_drop = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUS-1:0] ramp(input int first, input int cnt);
        logic [BUS-1:0] w;
        w = '0;
        for (int i = 0; i < cnt; i++) w[i*ST +: ST] = ST'(first + i);
        return w;
    endfunction

    // Word made of packet beats [first, first+NST), missing beats read as zero.
    function automatic void m_emit(input int first, input bit last, input bit err);
        logic [BUS-1:0] w;
        bit e;
        w = '0;
        for (int i = first; i < m_pkt.size() && i < first + NST; i++) w[(i-first)*ST +: ST] = m_pkt[i];
        e = err | m_drop;
        exp_q.push_back({last, e, w});
        if (e) exp_err_words++;
        m_drop = 1'b0;
    endfunction

    function automatic void m_beat(input bit sop, input bit eop, input byte unsigned d);
        int n;
        bit err;
        if (m_mode == 1 && sop) begin
            n = m_pkt.size();
            m_emit((n / NST) * NST, 1'b1, 1'b1);
            m_mode = 0;
        end
        if (m_mode != 1) begin
            if (sop) begin
                m_pkt.delete();
                m_mode = 1;
            end else begin
                if (m_mode == 0) m_drop = 1'b1;
                else if (eop) m_mode = 0;
                return;
            end
        end
        m_pkt.push_back(d);
        n = m_pkt.size();
        if (eop || n % NST == 0) begin
            if (n == PKT) err = !eop;
            else err = eop;
            m_emit(((n - 1) / NST) * NST, eop || n == PKT, err);
            if (eop) m_mode = 0;
            else if (n == PKT) m_mode = 2;
        end
    endfunction

    function automatic void m_reset();
        m_mode = 0;
        m_pkt.delete();
        m_drop = 1'b0;
    endfunction

    // bus_ready generator: 0 = always ready, 1 = random, 2 = one 20-cycle stall on the first valid word
    int rdy_mode = 0;
    int stall_left = 0;
    bit stall_armed = 1'b0;
    always @(posedge clk_st) begin
        #1;
        case (rdy_mode)
            0: bus_ready = 1'b1;
            1: bus_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (stall_armed && bus_valid) begin
                    stall_left = 20;
                    stall_armed = 1'b0;
                end
                if (stall_left > 0) begin
                    bus_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus_ready = 1'b1;
                end
            end
        endcase
    end

    // Output monitor
    logic [W-1:0] held;
    bit holding = 1'b0;
    always @(negedge clk_st) begin
        if (rst) begin
            holding = 1'b0;
        end else begin
            if (holding && bus_valid) chk("hold_stable", {bus_last, bus_err, bus_data}, held);
            if (bus_valid && !bus_ready) begin
                chk("src_rdy_when_stalled", W'(source_ready), W'(0));
                held = {bus_last, bus_err, bus_data};
                holding = 1'b1;
                stall_seen++;
            end else begin
                holding = 1'b0;
            end
            if (bus_valid && bus_ready) obs_q.push_back({bus_last, bus_err, bus_data});
            if (pkt_done) pkt_cnt++;
        end
    end

    task automatic send(input bit sop, input bit eop, input byte unsigned d);
        int waited;
        waited = 0;
        source_valid = 1'b1;
        source_sop = sop;
        source_eop = eop;
        source_data_s = d;
        @(negedge clk_st);
        while (!source_ready) begin
            waited++;
            if (waited > 200) begin
                chk("beat_accept_timeout", W'(0), W'(1));
                break;
            end
            @(negedge clk_st);
        end
        if (source_ready) m_beat(sop, eop, d);
        @(posedge clk_st);
        #1;
        source_valid = 1'b0;
        source_sop = 1'b0;
        source_eop = 1'b0;
    endtask

    task automatic send_ramp(input int n, input int first, input bit do_eop);
        for (int i = 0; i < n; i++) send(i == 0, do_eop && i == n - 1, byte'(first + i));
    endtask

    task automatic drain(input string tag);
        int n;
        int lasts;
        rdy_mode = 0;
        repeat (4) @(negedge clk_st);
        n = 0;
        while (bus_valid && n < 100) begin
            @(negedge clk_st);
            n++;
        end
        chk({tag, "_drained"}, W'(bus_valid), W'(0));
        repeat (2) @(negedge clk_st);
        chk({tag, "_word_count"}, W'(obs_q.size()), W'(exp_q.size()));
        lasts = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][W-1]) lasts++;
            if (i < obs_q.size()) chk({tag, "_word"}, obs_q[i], exp_q[i]);
        end
        chk({tag, "_pkt_done"}, W'(pkt_cnt), W'(lasts));
`ifdef ST2BUS_ERR_CNT_EN
        chk({tag, "_err_cnt"}, W'(err_cnt), W'(exp_err_words));
`endif
        @(posedge clk_st);
        #1;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        exp_q.delete();
        pkt_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        source_valid = 1'b0;
        repeat (2) @(posedge clk_st);
        #1;
        rst = 1'b0;
        m_reset();
        clear_obs();
        exp_err_words = 0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int kind;
        // Reset state
        repeat (3) @(posedge clk_st);
        #1;
        rst = 1'b0;
        @(negedge clk_st);
        chk("rst_bus_valid", W'(bus_valid), W'(0));
        chk("rst_bus_last", W'(bus_last), W'(0));
        chk("rst_bus_err", W'(bus_err), W'(0));
        chk("rst_pkt_done", W'(pkt_done), W'(0));
        chk("rst_bus_data", W'(bus_data), W'(0));
        chk("rst_source_ready", W'(source_ready), W'(1));
`ifdef ST2BUS_ERR_CNT_EN
        chk("rst_err_cnt", W'(err_cnt), W'(0));
`endif
        @(posedge clk_st);
        #1;

        // Clean 128-beat ramp, always ready
        send_ramp(128, 0, 1'b1);
        drain("clean");
        chk("clean_w0", obs_q[0], {2'b00, ramp(0, 64)});
        chk("clean_w1", obs_q[1], {2'b10, ramp(64, 64)});
        chk("clean_pkt_done_one", W'(pkt_cnt), W'(1));
        clear_obs();

        // Same packet with a 20-cycle output stall on word 0
        stall_seen = 0;
        stall_armed = 1'b1;
        rdy_mode = 2;
        send_ramp(128, 0, 1'b1);
        drain("stall");
        chk("stall_cycles", W'(stall_seen), W'(20));
        chk("stall_w0", obs_q[0], {2'b00, ramp(0, 64)});
        chk("stall_w1", obs_q[1], {2'b10, ramp(64, 64)});
        clear_obs();

        // Early eop on beat 70
        send_ramp(71, 0, 1'b1);
        drain("early_eop");
        chk("early_eop_w1", obs_q[1], {2'b11, ramp(64, 7)});
        clear_obs();

        // Three beats without sop, then a valid packet
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, byte'(8'hA0 + i));
        send_ramp(128, 16, 1'b1);
        drain("drop");
        chk("drop_w0", obs_q[0], {2'b01, ramp(16, 64)});
        chk("drop_w1", obs_q[1], {2'b10, ramp(80, 64)});
        clear_obs();

        // Reset mid-packet, then a clean packet
        send_ramp(40, 0, 1'b0);
        do_reset();
        send_ramp(128, 128, 1'b1);
        drain("mid_rst");
        chk("mid_rst_w0", obs_q[0], {2'b00, ramp(128, 64)});
        chk("mid_rst_w1", obs_q[1], {2'b10, ramp(192, 64)});
        clear_obs();

        // Two early-eop packets after a reset: two error words
        send_ramp(71, 0, 1'b1);
        send_ramp(71, 0, 1'b1);
        drain("two_err");
`ifdef ST2BUS_ERR_CNT_EN
        chk("two_err_err_cnt", W'(err_cnt), W'(2));
`endif
        clear_obs();

        // Randomized traffic with random backpressure
        rdy_mode = 1;
        for (int p = 0; p < 30; p++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) send(1'b0, 1'b0, byte'($urandom_range(0, 255)));
            end else begin
                len = (kind < 4) ? PKT : $urandom_range(2, 140);
                for (int i = 0; i < len; i++) begin
                    send(i == 0, (kind != 1) && i == len - 1, byte'($urandom_range(0, 255)));
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk_st);
                        #1;
                    end
                end
            end
        end
        drain("random");
        clear_obs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
